// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - handshake and control bundle between datapath and sequencer
//
// Purpose: groups the signals exchanged between the 8-bit ALU datapath
// register block and alu_sequencer.
//
// Signals:
//   start    datapath -> sequencer  operation request, held until stop
//   opcode   datapath -> sequencer  00 add, 01 sub, 10 multiply, 11 divide
//   q0       datapath -> sequencer  Q[0]
//   q1       datapath -> sequencer  Booth extra bit Q-1
//   a_msb    datapath -> sequencer  A[7], accumulator sign
//   cs       sequencer -> datapath  control word (one step per cycle)
//   stop     sequencer -> datapath  end-of-operation pulse
//   busy     sequencer -> datapath  high outside IDLE
//   iter     sequencer -> datapath  remaining iterations
//   rem_neg  sequencer -> datapath  divide left a negative remainder
//
// Modports: master = datapath side, slave = sequencer side.

interface alu_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [1:0]       opcode;
  logic             q0;
  logic             q1;
  logic             a_msb;
  logic [7:0]       cs;
  logic             stop;
  logic             busy;
  logic [CNT_W-1:0] iter;
  logic             rem_neg;

  modport master (
    output start, opcode, q0, q1, a_msb,
    input  cs, stop, busy, iter, rem_neg
  );

  modport slave (
    input  start, opcode, q0, q1, a_msb,
    output cs, stop, busy, iter, rem_neg
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - control sequencer for the 8-bit ALU datapath
//
// Purpose: turns a start request plus opcode into a per-cycle control word
// for the datapath. Add/sub take one arithmetic step. Multiply runs Booth
// radix-2 with WIDTH ARITH/SHIFT pairs. Divide runs non-restoring division
// with WIDTH SHIFT/ARITH pairs. Every operation ends with WRITE, then a one
// cycle DONE (stop), then WAIT_CLR until start is released.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   alu_sequencer_if.slave
//         inputs : start, opcode, q0, q1, a_msb
//         outputs: cs[7:0], stop, busy, iter[CNT_W-1:0], rem_neg
//
// cs bits: [0] idle, [1] load, [2] add, [3] subtract, [4] shift,
//          [5] write result, [6] done, [7] wait-for-clear.

module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_sequencer_if.slave    bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_ARITH    = 3'd2;
  localparam logic [2:0] S_SHIFT    = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_WAIT_CLR = 3'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [CNT_W-1:0] ITER_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ITER_ZERO = '0;

  logic [2:0]       state;
  logic [1:0]       op;
  logic             div_sub;
  logic [CNT_W-1:0] iter_q;
  logic             rem_neg_q;
  logic [7:0]       cs;

  // The last iteration is the one that sees iter == 1 before decrementing.
  logic last_iter;
  assign last_iter = (iter_q <= ITER_ONE);

  // Saturating decrement: iter can never wrap below zero.
  logic [CNT_W-1:0] iter_dec;
  assign iter_dec = (iter_q == ITER_ZERO) ? ITER_ZERO : (iter_q - ITER_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= OP_ADD;
      div_sub   <= 1'b1;
      iter_q    <= ITER_ZERO;
      rem_neg_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op        <= bus.opcode;
            iter_q    <= ITER_INIT;
            rem_neg_q <= 1'b0;
            state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (op == OP_DIV) begin
            // Non-restoring division always begins with a trial subtract.
            div_sub <= 1'b1;
            state   <= S_SHIFT;
          end else begin
            state <= S_ARITH;
          end
        end

        S_ARITH: begin
          case (op)
            OP_MUL: begin
              state <= S_SHIFT;
            end
            OP_DIV: begin
              iter_q <= iter_dec;
              state  <= last_iter ? S_WRITE : S_SHIFT;
            end
            default: begin
              // Add/sub: a single step; iter is parked at zero for WRITE on.
              iter_q <= ITER_ZERO;
              state  <= S_WRITE;
            end
          endcase
        end

        S_SHIFT: begin
          case (op)
            OP_MUL: begin
              iter_q <= iter_dec;
              state  <= last_iter ? S_WRITE : S_ARITH;
            end
            OP_DIV: begin
              // The sign of A before this shift picks the next step:
              // non-negative -> subtract, negative -> add back.
              div_sub <= ~bus.a_msb;
              state   <= S_ARITH;
            end
            default: begin
              state <= S_WRITE;
            end
          endcase
        end

        S_WRITE: begin
          if (op == OP_DIV) begin
            rem_neg_q <= bus.a_msb;
          end
          state <= S_DONE;
        end

        S_DONE: begin
          state <= S_WAIT_CLR;
        end

        S_WAIT_CLR: begin
          // Holding start here must not re-trigger; wait for a full release.
          if (!bus.start) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Control word decode. Only the multiply ARITH step looks at live inputs
  // (Booth pair q0/q1); everything else depends on registered state/flags.
  always_comb begin
    cs = 8'b0;
    case (state)
      S_IDLE:     cs[0] = 1'b1;
      S_LOAD:     cs[1] = 1'b1;
      S_ARITH: begin
        case (op)
          OP_ADD: cs[2] = 1'b1;
          OP_SUB: cs[3] = 1'b1;
          OP_MUL: begin
            // Booth pair {Q0,Q-1}: 01 add M, 10 subtract M, 00/11 nothing.
            cs[2] = ~bus.q0 &  bus.q1;
            cs[3] =  bus.q0 & ~bus.q1;
          end
          default: begin
            cs[3] =  div_sub;
            cs[2] = ~div_sub;
          end
        endcase
      end
      S_SHIFT:    cs[4] = 1'b1;
      S_WRITE:    cs[5] = 1'b1;
      S_DONE:     cs[6] = 1'b1;
      S_WAIT_CLR: cs[7] = 1'b1;
      default:    cs    = 8'b0;
    endcase
  end

  assign bus.cs      = cs;
  assign bus.stop    = (state == S_DONE);
  assign bus.busy    = (state != S_IDLE);
  assign bus.iter    = iter_q;
  assign bus.rem_neg = rem_neg_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer

module tb_alu_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  alu_sequencer_if #(.CNT_W(CNT_W)) bus();

  alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_rem_neg = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full operation from IDLE back to IDLE. mode: 0 random inputs,
  // 1 Booth pair fixed at 10, 2 Booth pair fixed at 11, 3 divide with a_msb
  // alternating 0,1,0.. per SHIFT and 1 in WRITE. hold = cycles start stays
  // high after stop.
  task automatic run_op(input logic [1:0] op, input int mode, input int hold);
    int   lat;
    int   shifts;
    int   eiter;
    logic exp_sub;
    logic is_shift;
    logic q0v, q1v, av;
    logic [7:0] ecs;
    lat     = op[1] ? 2*WIDTH + 3 : 4;
    shifts  = 0;
    exp_sub = 1'b1;
    bus.opcode = op;
    bus.start  = 1'b1;
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk);
      #1;
      q0v = 1'($urandom_range(0, 1));
      q1v = 1'($urandom_range(0, 1));
      av  = 1'($urandom_range(0, 1));
      if (mode == 1) begin q0v = 1'b1; q1v = 1'b0; end
      if (mode == 2) begin q0v = 1'b1; q1v = 1'b1; end
      if (op == 2'b10)      is_shift = (n >= 3 && n <= lat-2 && (n % 2) == 1);
      else if (op == 2'b11) is_shift = (n >= 2 && n <= lat-2 && (n % 2) == 0);
      else                  is_shift = 1'b0;
      if (mode == 3 && op == 2'b11 && is_shift) av = 1'(shifts % 2);
      if (mode == 3 && n == lat-1) av = 1'b1;
      bus.q0     = q0v;
      bus.q1     = q1v;
      bus.a_msb  = av;
      bus.opcode = 2'($urandom);
      bus.start  = (n == lat) ? 1'b1 : 1'($urandom_range(0, 1));
      if (n == 1) exp_rem_neg = 1'b0;
      @(negedge clk);
      if (n == 1)            ecs = 8'h02;
      else if (n == lat)     ecs = 8'h40;
      else if (n == lat-1)   ecs = 8'h20;
      else if (is_shift)     ecs = 8'h10;
      else begin
        case (op)
          2'b00: ecs = 8'h04;
          2'b01: ecs = 8'h08;
          2'b10: ecs = ({q0v, q1v} == 2'b01) ? 8'h04 :
                       ({q0v, q1v} == 2'b10) ? 8'h08 : 8'h00;
          default: ecs = exp_sub ? 8'h08 : 8'h04;
        endcase
      end
      if (n == 1)        eiter = WIDTH;
      else if (!op[1])   eiter = (n == 2) ? WIDTH : 0;
      else               eiter = (n <= lat-2) ? WIDTH - (n-2)/2 : 0;
      check($sformatf("cs op%0d n%0d", op, n), 32'(bus.cs), 32'(ecs));
      check($sformatf("stop op%0d n%0d", op, n), 32'(bus.stop), 32'(n == lat));
      check($sformatf("busy op%0d n%0d", op, n), 32'(bus.busy), 32'd1);
      check($sformatf("iter op%0d n%0d", op, n), 32'(bus.iter), 32'(eiter));
      check($sformatf("rem_neg op%0d n%0d", op, n), 32'(bus.rem_neg), 32'(exp_rem_neg));
      if (is_shift && op == 2'b11) begin
        exp_sub = ~av;
        shifts++;
      end
      if (n == lat-1 && op == 2'b11) exp_rem_neg = av;
    end
    for (int k = 0; k <= hold; k++) begin
      @(posedge clk);
      #1;
      bus.start = (k < hold);
      bus.q0    = 1'($urandom_range(0, 1));
      bus.a_msb = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("wait cs op%0d k%0d", op, k), 32'(bus.cs), 32'h80);
      check($sformatf("wait stop op%0d k%0d", op, k), 32'(bus.stop), 32'd0);
      check($sformatf("wait iter op%0d k%0d", op, k), 32'(bus.iter), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check($sformatf("idle cs op%0d", op), 32'(bus.cs), 32'h01);
    check($sformatf("idle busy op%0d", op), 32'(bus.busy), 32'd0);
    check($sformatf("idle iter op%0d", op), 32'(bus.iter), 32'd0);
    check($sformatf("idle rem_neg op%0d", op), 32'(bus.rem_neg), 32'(exp_rem_neg));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.opcode = 2'b00;
    bus.q0     = 1'b0;
    bus.q1     = 1'b0;
    bus.a_msb  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset cs", 32'(bus.cs), 32'h01);
    check("reset stop", 32'(bus.stop), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset iter", 32'(bus.iter), 32'd0);
    check("reset rem_neg", 32'(bus.rem_neg), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'b00, 0, 0);
    run_op(2'b01, 0, 1);
    run_op(2'b10, 1, 0);
    run_op(2'b10, 2, 0);
    run_op(2'b11, 3, 5);
    run_op(2'b00, 0, 0);
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom), 0, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a multiply, right after a divide left rem_neg=1.
    run_op(2'b11, 3, 0);
    bus.opcode = 2'b10;
    bus.start  = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      #1;
      bus.q0 = 1'($urandom_range(0, 1));
      bus.q1 = 1'($urandom_range(0, 1));
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst cs", 32'(bus.cs), 32'h01);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst iter", 32'(bus.iter), 32'd0);
    check("midrst stop", 32'(bus.stop), 32'd0);
    check("midrst rem_neg", 32'(bus.rem_neg), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check($sformatf("postrst stop k%0d", k), 32'(bus.stop), 32'd0);
      check($sformatf("postrst cs k%0d", k), 32'(bus.cs), 32'h01);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
